conv1d_engine: RTL and testbench

CONV1D_ENGINE -- requirements
Module: conv1d_engine

---
 rtl/conv1d_engine.sv | 127 ++++++++++++
 tb/tb_conv1d_engine.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/conv1d_engine.sv
// 1-D valid-mode convolution engine: on-chip sample/kernel buffers, one MAC per cycle, ready/valid output.
// Optional macro CONV1D_SAT_EN: saturate results to OUT_W; otherwise results wrap to the low OUT_W bits.
module conv1d_engine #(
  parameter int DATA_W = 8,
  parameter int N_MAX  = 1024,
  parameter int K_MAX  = 64,
  parameter int OUT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ld_valid,
  input  logic                            ld_sel,
  input  logic [$clog2(N_MAX)-1:0]        ld_addr,
  input  logic signed [DATA_W-1:0]        ld_data,
  input  logic                            start,
  input  logic [$clog2(N_MAX):0]          n_len,
  input  logic [$clog2(K_MAX):0]          k_len,
  output logic                            busy,
  output logic                            done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         out_data
);
  localparam int AW    = $clog2(N_MAX);
  localparam int KW    = $clog2(K_MAX);
  localparam int PW    = 2*DATA_W;
  localparam int ACC_W = PW + KW;

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, EMIT, FIN} state_t;
  state_t state, nxt;

  logic signed [DATA_W-1:0] xbuf [N_MAX];
  logic signed [DATA_W-1:0] hbuf [K_MAX];
  logic signed [DATA_W-1:0] x_rd, h_rd;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc, sum;
  logic [AW:0]              n_q, j_q;
  logic [KW:0]              k_q, tap_q, rd_tap;
  logic [AW-1:0]            xa;
  logic                     done_q;
  logic signed [OUT_W-1:0]  out_q;

  function automatic logic signed [OUT_W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef CONV1D_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(64'sd1 <<< (OUT_W-1)));
    if (v > SMAX)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < SMIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else               return OUT_W'(v);
`else
    return OUT_W'(v);
`endif
  endfunction

  // Tap 0 is fetched during CLEAR; each MAC cycle fetches the next tap.
  assign rd_tap = (state == CLEAR) ? '0 : tap_q;
  assign xa     = AW'(j_q + (AW+1)'(rd_tap));
  assign sum    = acc + ACC_W'(prod);

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign out_valid = (state == EMIT);
  assign out_data  = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = (k_len != '0 && 32'(k_len) <= 32'(n_len)) ? CLEAR : FIN;
      CLEAR: nxt = MAC;
      MAC:   if (tap_q == k_q) nxt = DRAIN;
      DRAIN: nxt = EMIT;
      EMIT:  if (out_ready) nxt = (j_q < (n_q - (AW+1)'(k_q))) ? CLEAR : FIN;
      FIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Buffers are never reset so their contents survive reset and successive runs.
  always_ff @(posedge clk) begin
    x_rd <= xbuf[xa];
    h_rd <= hbuf[rd_tap[KW-1:0]];
    if (ld_valid && state == IDLE) begin
      if (ld_sel) hbuf[ld_addr[KW-1:0]] <= ld_data;
      else        xbuf[ld_addr]         <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      k_q    <= '0;
      j_q    <= '0;
      tap_q  <= '0;
      acc    <= '0;
      prod   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      case (state)
        IDLE: if (start) begin
          n_q <= n_len;
          k_q <= k_len;
          j_q <= '0;
        end
        CLEAR: begin
          acc   <= '0;
          prod  <= '0;
          tap_q <= (KW+1)'(1);
        end
        MAC: begin
          acc   <= sum;
          prod  <= PW'(x_rd) * PW'(h_rd);
          tap_q <= tap_q + (KW+1)'(1);
        end
        DRAIN: out_q <= reduce(sum);
        EMIT:  if (out_ready) j_q <= j_q + (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1d_engine.sv
// Directed bench for conv1d_engine: timing, back-pressure, degenerate lengths, reset abort, busy lockout.
module tb_conv1d_engine;
  localparam int DATA_W = 8, N_MAX = 1024, K_MAX = 64, OUT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n, ld_valid, ld_sel, start, busy, done, out_valid, out_ready;
  logic [9:0]               ld_addr;
  logic signed [DATA_W-1:0] ld_data;
  logic [10:0]              n_len;
  logic [6:0]               k_len;
  logic signed [OUT_W-1:0]  out_data;

  conv1d_engine #(.DATA_W(DATA_W), .N_MAX(N_MAX), .K_MAX(K_MAX), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .n_len(n_len), .k_len(k_len), .busy(busy),
    .done(done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int total = 0, bad = 0;
  int exp_q[$];

  task automatic check(input string tag, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic load(input logic sel, input int addr, input int data);
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = 10'(addr); ld_data = 8'(data);
    @(posedge clk); #1 ld_valid = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 5; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < 3; i++) load(1'b1, i, 1);
  endtask

  // Runs one convolution and checks results from exp_q, per-result latency, done timing and busy length.
  task automatic run(input int n, input int k, input int stall, input bit poke, input string tag);
    int cnt, busy_n, seen;
    @(negedge clk);
    n_len = 11'(n); k_len = 7'(k); start = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1 start = 1'b0;
    foreach (exp_q[r]) begin
      cnt = 0;
      do begin
        @(posedge clk); #1 cnt++;
        if (poke && r == 0 && cnt == 2) begin
          start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 8'sd100;
        end
        if (poke && r == 0 && cnt == 3) ld_sel = 1'b1;
        if (poke && r == 0 && cnt == 4) begin start = 1'b0; ld_valid = 1'b0; end
      end while (!out_valid && cnt < 200);
      check($sformatf("%s latency r%0d", tag, r), cnt, k + 2);
      if (stall > 0 && r == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          check($sformatf("%s hold s%0d", tag, s), out_valid ? int'(out_data) : -99999, exp_q[r]);
        end
        out_ready = 1'b1;
      end
      check($sformatf("%s data r%0d", tag, r), int'(out_data), exp_q[r]);
      @(posedge clk); #1;
    end
    // Counted from the start edge (no results) or the last transfer edge: FIN, then done.
    cnt = 0; seen = 0; busy_n = busy ? 1 : 0;
    do begin
      @(posedge clk); #1 cnt++;
      if (busy) busy_n++;
      if (out_valid) seen++;
    end while (!done && cnt < 200);
    check({tag, " done latency"}, cnt, 1);
    check({tag, " busy cycles"}, busy_n, 1);
    check({tag, " extra valid"}, seen, 0);
    @(posedge clk); #1 check({tag, " done width"}, int'(done), 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; n_len = '0; k_len = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_data", int'(out_data), 0);
    @(negedge clk) rst_n = 1'b1;

    load_basic();
    exp_q = '{6, 9, 12};
    run(5, 3, 0, 1'b0, "basic");
    run(5, 3, 10, 1'b0, "stall");

    // start and loads while busy must not disturb this run or the buffers
    run(5, 3, 0, 1'b1, "poke");
    run(5, 3, 0, 1'b0, "after poke");

    // reset during MAC of j=1
    @(negedge clk); n_len = 11'd5; k_len = 7'd3; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    do begin @(posedge clk); #1 cnt++; end while (!out_valid && cnt < 200);
    check("abort first valid", cnt, 5);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    check("abort busy", int'(busy), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (done || out_valid) cnt++; end
    check("abort no output", cnt, 0);
    run(5, 3, 0, 1'b0, "post reset");

    // mixed-sign pattern
    load(1'b0, 0, 10); load(1'b0, 1, -20); load(1'b0, 2, 30); load(1'b0, 3, -40);
    load(1'b1, 0, 2);  load(1'b1, 1, -1);
    exp_q = '{40, -70, 100};
    run(4, 2, 0, 1'b0, "mixed");

    // full-scale N=K=64: exact sum 1048576
    for (int i = 0; i < 64; i++) begin load(1'b0, i, -128); load(1'b1, i, -128); end
`ifdef CONV1D_SAT_EN
    exp_q = '{32767};
`else
    exp_q = '{0};
`endif
    run(64, 64, 0, 1'b0, "fullscale");

    exp_q = {};
    run(3, 4, 0, 1'b0, "k>n");
    run(3, 0, 0, 1'b0, "k=0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
